// File: rtl/gb_apu_pkg.sv
// Shared APU definitions: duty selection, duty waveforms and length limits.
// Also provides the frequency-timer reload helper.
package gb_apu_pkg;

    typedef enum logic [1:0] {
        DUTY_12 = 2'd0,
        DUTY_25 = 2'd1,
        DUTY_50 = 2'd2,
        DUTY_75 = 2'd3
    } duty_t;

    // Indexed [duty][step]; step 0 is bit 0 of each pattern.
    localparam logic [3:0][7:0] DUTY_PATTERNS = {
        8'b01111110,
        8'b10000111,
        8'b10000001,
        8'b00000001
    };

    localparam int LENGTH_MAX = 64;

    function automatic logic [11:0] freq_reload(input logic [10:0] freq);
        return 12'd2048 - {1'b0, freq};
    endfunction

endpackage

// File: rtl/gb_lengthCounter.sv
// Down-counting length timer with trigger reload; pulses expired when a tick
// takes the count to zero. Width/maximum are parameters so Channel 3 can reuse it.
module gb_lengthCounter #(
    parameter int W   = 7,
    parameter int MAX = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         trigger,
    input  logic         tick,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W-1:0] written;

    // A write in the trigger cycle lands first, so the zero check sees it.
    always_comb begin
        written = load ? load_value : count_q;
        count_d = count_q;
        expired = 1'b0;
        if (trigger) begin
            count_d = (written == '0) ? W'(MAX) : written;
        end else if (load) begin
            count_d = load_value;
        end else if (tick && enable && (count_q != '0)) begin
            count_d = count_q - W'(1);
            expired = (count_q == W'(1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/gb_pulse_waveform.sv
// Square-wave generator for APU pulse channels: prescaler, frequency timer,
// 8-step duty sequencer, length counter and channel-active flag.
module gb_pulse_waveform
    import gb_apu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic        clk_length,
    input  logic        length_enable,
    input  logic        length_write,
    input  logic [5:0]  length_value,
    input  logic [1:0]  duty,
    input  logic [10:0] shadow_frequency,
    input  logic        overflow,
    input  logic        dac_enable,
    output logic        wave_out,
    output logic        channel_active
);

    logic [1:0]  presc_q, presc_d;
    logic [11:0] freq_timer_q, freq_timer_d;
    logic [2:0]  step_q, step_d;
    logic        reload_pending_q, reload_pending_d;
    logic        active_q, active_d;
    duty_t       duty_q, duty_d;

    logic        tick;
    logic [6:0]  len_count;
    logic        len_expired;
    logic [6:0]  len_load_value;

    assign tick           = (presc_q == 2'd3);
    assign len_load_value = 7'(LENGTH_MAX) - {1'b0, length_value};

    gb_lengthCounter #(
        .W   (7),
        .MAX (LENGTH_MAX)
    ) u_length (
        .clk        (clk),
        .reset      (reset),
        .load       (length_write),
        .load_value (len_load_value),
        .trigger    (trigger),
        .tick       (clk_length),
        .enable     (length_enable),
        .count      (len_count),
        .expired    (len_expired)
    );

    // Prescaler is held at zero through the reload cycle so the first step
    // lands exactly 4*(2048-f) clocks after the timer reload.
    always_comb begin
        presc_d          = presc_q + 2'd1;
        reload_pending_d = trigger;
        freq_timer_d     = freq_timer_q;
        step_d           = step_q;
        if (trigger || reload_pending_q) begin
            presc_d = 2'd0;
        end
        if (reload_pending_q) begin
            freq_timer_d = freq_reload(shadow_frequency);
        end else if (tick && !trigger) begin
            if (freq_timer_q == 12'd1) begin
                freq_timer_d = freq_reload(shadow_frequency);
                step_d       = step_q + 3'd1;
            end else begin
                freq_timer_d = freq_timer_q - 12'd1;
            end
        end
    end

    // Trigger overrides mute conditions in its own cycle; mutes stick until
    // the next trigger.
    always_comb begin
        active_d = active_q;
        duty_d   = duty_t'(duty);
        if (trigger) begin
            active_d = dac_enable;
        end else if (overflow || !dac_enable || len_expired) begin
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q          <= 2'd0;
            freq_timer_q     <= 12'd2048;
            step_q           <= 3'd0;
            reload_pending_q <= 1'b0;
            active_q         <= 1'b0;
            duty_q           <= DUTY_12;
        end else begin
            presc_q          <= presc_d;
            freq_timer_q     <= freq_timer_d;
            step_q           <= step_d;
            reload_pending_q <= reload_pending_d;
            active_q         <= active_d;
            duty_q           <= duty_d;
        end
    end

    assign channel_active = active_q;
    assign wave_out       = DUTY_PATTERNS[duty_q][step_q] & active_q;

endmodule

// File: tb/tb_gb_pulse_waveform.sv
// Directed bench for gb_pulse_waveform: inputs driven and outputs sampled on
// the falling edge, expected values hand-computed per step.
module tb_gb_pulse_waveform;

    logic        clk;
    logic        reset;
    logic        trigger;
    logic        clk_length;
    logic        length_enable;
    logic        length_write;
    logic [5:0]  length_value;
    logic [1:0]  duty;
    logic [10:0] shadow_frequency;
    logic        overflow;
    logic        dac_enable;
    logic        wave_out;
    logic        channel_active;

    int tests = 0;
    int fails = 0;

    gb_pulse_waveform dut (
        .clk              (clk),
        .reset            (reset),
        .trigger          (trigger),
        .clk_length       (clk_length),
        .length_enable    (length_enable),
        .length_write     (length_write),
        .length_value     (length_value),
        .duty             (duty),
        .shadow_frequency (shadow_frequency),
        .overflow         (overflow),
        .dac_enable       (dac_enable),
        .wave_out         (wave_out),
        .channel_active   (channel_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic wave_exp [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        reset            = 1'b1;
        trigger          = 1'b0;
        clk_length       = 1'b0;
        length_enable    = 1'b0;
        length_write     = 1'b0;
        length_value     = 6'd0;
        duty             = 2'd2;
        shadow_frequency = 11'd2047;
        overflow         = 1'b0;
        dac_enable       = 1'b1;

        // Reset state
        cyc(2);
        check("rst_active", 32'(channel_active), 32'd0);
        check("rst_wave", 32'(wave_out), 32'd0);
        check("rst_step", 32'(dut.step_q), 32'd0);
        check("rst_presc", 32'(dut.presc_q), 32'd0);
        check("rst_timer", 32'(dut.freq_timer_q), 32'd2048);
        check("rst_len", 32'(dut.u_length.count_q), 32'd0);
        check("rst_pending", 32'(dut.reload_pending_q), 32'd0);

        // First tick four clocks after reset release
        reset = 1'b0;
        cyc(3);
        check("first_tick_pre", 32'(dut.freq_timer_q), 32'd2048);
        cyc(1);
        check("first_tick", 32'(dut.freq_timer_q), 32'd2047);

        // Duty 10 at f=2047: one step per 4 clk, 1,1,1,0,0,0,0,1
        trigger = 1'b1;
        cyc(1);
        trigger = 1'b0;
        check("t1_active", 32'(channel_active), 32'd1);
        check("t1_len64", 32'(dut.u_length.count_q), 32'd64);
        check("t1_wave0", 32'(wave_out), 32'd1);
        cyc(1);
        check("t1_reload", 32'(dut.freq_timer_q), 32'd1);
        cyc(3);
        check("t1_step0_hold", 32'(dut.step_q), 32'd0);
        for (int s = 1; s < 8; s++) begin
            cyc(1);
            check("t1_step", 32'(dut.step_q), 32'(s));
            check("t1_wave", 32'(wave_out), 32'(wave_exp[s]));
            cyc(3);
            check("t1_wave_hold", 32'(wave_out), 32'(wave_exp[s]));
        end

        // Asynchronous reset mid-period
        reset = 1'b1;
        #1;
        check("mid_rst_active", 32'(channel_active), 32'd0);
        check("mid_rst_wave", 32'(wave_out), 32'd0);
        check("mid_rst_step", 32'(dut.step_q), 32'd0);
        check("mid_rst_len", 32'(dut.u_length.count_q), 32'd0);
        cyc(1);
        reset = 1'b0;
        cyc(1);

        // Duty 00 at f=1024, trigger with simultaneous length tick from len=0
        duty             = 2'd0;
        shadow_frequency = 11'd1024;
        trigger          = 1'b1;
        clk_length       = 1'b1;
        length_enable    = 1'b1;
        cyc(1);
        trigger       = 1'b0;
        clk_length    = 1'b0;
        length_enable = 1'b0;
        check("t2_active", 32'(channel_active), 32'd1);
        check("t2_len64", 32'(dut.u_length.count_q), 32'd64);
        check("t2_wave_hi", 32'(wave_out), 32'd1);
        cyc(1);
        check("t2_reload", 32'(dut.freq_timer_q), 32'd1024);
        cyc(4095);
        check("t2_step0_end", 32'(wave_out), 32'd1);
        cyc(1);
        check("t2_step1", 32'(dut.step_q), 32'd1);
        check("t2_wave_lo", 32'(wave_out), 32'd0);
        cyc(28671);
        check("t2_step7", 32'(dut.step_q), 32'd7);
        check("t2_wave7", 32'(wave_out), 32'd0);
        cyc(1);
        check("t2_wrap", 32'(dut.step_q), 32'd0);
        check("t2_wave_wrap", 32'(wave_out), 32'd1);

        // Length expiry: 64-60 = 4 ticks
        length_value = 6'd60;
        length_write = 1'b1;
        cyc(1);
        length_write = 1'b0;
        check("t3_len_write", 32'(dut.u_length.count_q), 32'd4);
        length_enable = 1'b1;
        trigger       = 1'b1;
        cyc(1);
        trigger = 1'b0;
        check("t3_active", 32'(channel_active), 32'd1);
        check("t3_len_keep", 32'(dut.u_length.count_q), 32'd4);
        for (int i = 1; i < 4; i++) begin
            clk_length = 1'b1;
            cyc(1);
            clk_length = 1'b0;
            check("t3_len_tick", 32'(dut.u_length.count_q), 32'(4 - i));
            check("t3_still_active", 32'(channel_active), 32'd1);
        end
        clk_length = 1'b1;
        cyc(1);
        clk_length = 1'b0;
        check("t3_expired", 32'(channel_active), 32'd0);
        check("t3_len0", 32'(dut.u_length.count_q), 32'd0);
        cyc(5);
        check("t3_wave_off", 32'(wave_out), 32'd0);
        check("t3_stays_off", 32'(channel_active), 32'd0);

        // Write together with trigger, then write together with length tick
        length_value = 6'd63;
        length_write = 1'b1;
        trigger      = 1'b1;
        cyc(1);
        trigger = 1'b0;
        check("t3_wr_trig_len", 32'(dut.u_length.count_q), 32'd1);
        check("t3_wr_trig_act", 32'(channel_active), 32'd1);
        length_value = 6'd50;
        clk_length   = 1'b1;
        cyc(1);
        length_write  = 1'b0;
        clk_length    = 1'b0;
        length_enable = 1'b0;
        check("t3_wr_tick_len", 32'(dut.u_length.count_q), 32'd14);
        check("t3_wr_tick_act", 32'(channel_active), 32'd1);

        // Overflow mute and trigger-cycle overflow
        overflow = 1'b1;
        cyc(1);
        overflow = 1'b0;
        check("t4_ovf_mute", 32'(channel_active), 32'd0);
        check("t4_ovf_wave", 32'(wave_out), 32'd0);
        cyc(3);
        check("t4_ovf_sticky", 32'(channel_active), 32'd0);
        trigger  = 1'b1;
        overflow = 1'b1;
        cyc(1);
        trigger  = 1'b0;
        overflow = 1'b0;
        check("t4_trig_ovf", 32'(channel_active), 32'd1);
        cyc(2);
        check("t4_trig_ovf_hold", 32'(channel_active), 32'd1);

        // DAC disable mute, then trigger with DAC off
        dac_enable = 1'b0;
        cyc(1);
        check("t5_dac_mute", 32'(channel_active), 32'd0);
        dac_enable = 1'b1;
        cyc(1);
        check("t5_dac_sticky", 32'(channel_active), 32'd0);
        shadow_frequency = 11'd2000;
        dac_enable       = 1'b0;
        trigger          = 1'b1;
        cyc(1);
        trigger = 1'b0;
        check("t5_trig_dac_off", 32'(channel_active), 32'd0);
        check("t5_pending", 32'(dut.reload_pending_q), 32'd1);
        cyc(1);
        check("t5_timer_reload", 32'(dut.freq_timer_q), 32'd48);
        check("t5_len_keep", 32'(dut.u_length.count_q), 32'd14);
        check("t5_wave_off", 32'(wave_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gb_pulse_waveform.md
# gb_pulse_waveform

Pulse waveform generator for APU Channels 1 and 2. It sits directly downstream of the Channel 1 sweep stage and consumes its `shadow_frequency` and `overflow` outputs; Channel 2 ties `overflow` low and drives `shadow_frequency` from its register. It owns the frequency timer, the 8-step duty sequencer, the 64-step length counter and the channel-active flag. It produces the 1-bit square wave that feeds the envelope and DAC stage.

## Interface
- No parameters. Duty patterns and constants come from the package.
- `clk` in 1: system clock, 2^22 Hz.
- `reset` in 1: asynchronous, active-high.
- `trigger` in 1: single-cycle channel trigger (NRx4 bit 7 write).
- `clk_length` in 1: single-cycle 256 Hz length tick from the frame sequencer.
- `length_enable` in 1: NRx4 bit 6.
- `length_write` in 1: single-cycle strobe for a write to NRx1.
- `length_value` in 6: NRx1[5:0].
- `duty` in 2: NRx1[7:6].
- `shadow_frequency` in 11: frequency from the sweep stage, or from the register for Channel 2.
- `overflow` in 1: sweep overflow; mutes the channel.
- `dac_enable` in 1: NRx2[7:3] != 0.
- `wave_out` out 1: current duty bit ANDed with `channel_active`.
- `channel_active` out 1: channel status for NR52.

## Operation
- Prescaler: a 2-bit free-running counter. It produces `tick` when its value is 3, i.e. one tick every 4 clk.
- Frequency timer: a 12-bit down counter `freq_timer`, range 1..2048.
  - On `tick`: if `freq_timer` == 1, reload with 2048 − `shadow_frequency` and set `step <= step + 1` (3-bit, wraps 7→0).
  - Otherwise, on `tick`, decrement.
- Duty patterns, indexed by `step` (bit 0 first):
  - 00 = 00000001
  - 01 = 10000001
  - 10 = 10000111
  - 11 = 01111110
- Length counter: 7-bit `len`, range 0..64.
  - `length_write`: `len <= 64 − length_value`.
  - `clk_length` && `length_enable` && `len` != 0: decrement. A transition to 0 clears `channel_active`.
- Trigger:
  - `channel_active <= dac_enable`.
  - If `len` == 0, then `len <= 64`.
  - Prescaler cleared.
  - `reload_pending <= 1`. On the following cycle, `freq_timer <= 2048 − shadow_frequency` and `reload_pending` clears. This one-cycle deferral lets the sweep stage latch its new shadow value first.
  - `step` is NOT reset by trigger.
- Mute conditions: `overflow` == 1 or `dac_enable` == 0 clears `channel_active` on the next edge. The flag stays clear until a trigger.
- Frequency changes mid-period take effect only at the next reload.

## Timing
- Reset values:
  - `channel_active` = 0, `wave_out` = 0
  - `step` = 0, prescaler = 0
  - `freq_timer` = 2048, `len` = 0, `reload_pending` = 0
- All outputs are registered or derived from registers; there is no combinational path from inputs to outputs.
- Step period is 4·(2048 − f) clk: 4 at f = 2047, 8192 at f = 0.
- After trigger at edge N: `channel_active` is valid at N+1, the timer is reloaded at N+2, and the first step advance is at N+2 + 4·(2048 − f).
- Simultaneous events:
  - `trigger` + `clk_length`: trigger wins; the tick is dropped.
  - `length_write` + `trigger`: the write is applied first, then the trigger's `len` == 0 check runs on the written value.
  - `trigger` + `overflow`: `overflow` is ignored in the trigger cycle and honoured from N+1 onward.
  - `trigger` + `dac_enable` = 0: the channel stays inactive, but the timer and length are still reloaded.
  - `length_write` + `clk_length`: the write wins.
- `reset` asserted mid-operation returns all state to reset values immediately (asynchronous). The first tick comes 4 clk after deassertion.

## Structure
- Package `gb_apu_pkg`: `duty_t` (2-bit enum: `DUTY_12`, `DUTY_25`, `DUTY_50`, `DUTY_75`), the `DUTY_PATTERNS` constant (4×8 bits), and `LENGTH_MAX` = 64.
- Sub-module `gb_lengthCounter`: length counter and expiry flag, parameterised on counter width. Channel 3 (256 steps) reuses it.
- The top level holds the prescaler, frequency timer, duty sequencer and active flag.

## Test plan
- Reset, then duty = 10, f = 2047, trigger → `wave_out` follows 1,1,1,0,0,0,0,1 (steps 0..7 = 10000111), each bit held 4 clk.
- f = 1024, duty = 00 → one step every 4096 clk; `wave_out` high for 4096 clk out of each 32768.
- `length_write` with `length_value` = 60, `length_enable` = 1, trigger, then 4 `clk_length` pulses → `channel_active` falls on the 4th pulse; `wave_out` = 0 thereafter.
- `len` = 0, then trigger → `len` = 64 and `channel_active` = 1. A simultaneous `clk_length` is ignored: `len` is still 64.
- `overflow` pulsed while active → `channel_active` = 0 next edge and stays 0 after `overflow` drops, until a trigger.
- `dac_enable` = 0 at trigger → `channel_active` stays 0. Assert `reset` mid-period → all outputs 0 and `step` = 0 immediately.
